// File: rtl/tx_link_scheduler.sv
// Byte-clock TX lane scheduler: comma training, round-robin framing of NUM_REQ sources, periodic alignment commas.
// Optional statistics outputs (frame_count, align_count) are enabled by defining TX_SCHED_STATS_EN.
module tx_link_scheduler #(
    parameter int          NUM_REQ      = 2,
    parameter int          TRAIN_LEN    = 64,
    parameter int          ALIGN_PERIOD = 256,
    parameter logic [7:0]  IDLE_K       = 8'hBC,
    parameter logic [7:0]  SOF_K        = 8'hFB,
    parameter logic [7:0]  EOF_K        = 8'hFD,
    parameter logic [7:0]  FILL_K       = 8'h1C,
    localparam int         GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_byte,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   train_restart,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_k,
    output logic                   link_up,
    output logic [GW-1:0]          grant_id,
    output logic                   busy
`ifdef TX_SCHED_STATS_EN
    ,
    output logic [15:0]            frame_count,
    output logic [15:0]            align_count
`endif
);

    localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam int AW = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;

    localparam logic [2:0] ST_TRAIN = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_SOF   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_EOF   = 3'd4;

    logic [2:0]    state;
    logic [TW-1:0] train_cnt;
    logic [AW-1:0] align_cnt;
    logic          align_due;
    logic          align_wrap;
    logic          due_clear;
    logic          arb_found;
    logic [GW-1:0] arb_idx;
    int            arb_pos;
    logic          cur_valid;
    logic          cur_last;
    logic [7:0]    cur_data;

    assign align_wrap = (align_cnt == AW'(ALIGN_PERIOD - 1));
    assign due_clear  = (state == ST_TRAIN) || (state == ST_IDLE) ||
                        ((state == ST_DATA) && align_due);
    assign cur_valid  = req_valid[grant_id];
    assign cur_last   = req_last[grant_id];
    assign cur_data   = req_data[grant_id*8 +: 8];

    // Round-robin search begins just after the most recently granted source.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = grant_id;
        arb_pos   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_pos = (int'(grant_id) + k) % NUM_REQ;
            if (!arb_found && req_valid[arb_pos]) begin
                arb_found = 1'b1;
                arb_idx   = GW'(arb_pos);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if ((state == ST_DATA) && !align_due) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_byte or posedge rst) begin
        if (rst) begin
            state     <= ST_TRAIN;
            train_cnt <= '0;
            align_cnt <= '0;
            align_due <= 1'b0;
            tx_data   <= IDLE_K;
            tx_k      <= 1'b1;
            link_up   <= 1'b0;
            grant_id  <= '0;
            busy      <= 1'b0;
        end else begin
            align_cnt <= align_wrap ? '0 : align_cnt + 1'b1;
            // A new wrap request wins over a same-cycle clear.
            align_due <= align_wrap | (align_due & ~due_clear);
            busy      <= (state == ST_SOF) || (state == ST_DATA) || (state == ST_EOF);
            tx_data   <= IDLE_K;
            tx_k      <= 1'b1;

            case (state)
                ST_TRAIN: begin
                    if (train_cnt == TW'(TRAIN_LEN - 1)) begin
                        train_cnt <= '0;
                        link_up   <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        train_cnt <= train_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (enable && arb_found) begin
                        grant_id <= arb_idx;
                        state    <= ST_SOF;
                    end
                end
                ST_SOF: begin
                    tx_data <= SOF_K;
                    state   <= ST_DATA;
                end
                ST_DATA: begin
                    if (align_due) begin
                        tx_data <= IDLE_K;
                    end else if (cur_valid) begin
                        tx_data <= cur_data;
                        tx_k    <= 1'b0;
                        if (cur_last) begin
                            state <= ST_EOF;
                        end
                    end else begin
                        tx_data <= FILL_K;
                    end
                end
                ST_EOF: begin
                    tx_data <= EOF_K;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_TRAIN;
                end
            endcase

            // Retraining overrides every transition and truncates any open frame.
            if (train_restart) begin
                state     <= ST_TRAIN;
                train_cnt <= '0;
                link_up   <= 1'b0;
            end
        end
    end

`ifdef TX_SCHED_STATS_EN
    always_ff @(posedge clk_byte or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
            align_count <= '0;
        end else begin
            if (state == ST_EOF) begin
                frame_count <= frame_count + 16'd1;
            end
            if ((state == ST_DATA) && align_due) begin
                align_count <= align_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Randomized scoreboard bench for tx_link_scheduler: a phase-based reference model predicts every output
// cycle; a negedge monitor pops and compares. Stats ports (TX_SCHED_STATS_EN) are connected but not checked.
module tb_tx_link_scheduler;

    localparam int         NUM_REQ      = 3;
    localparam int         TRAIN_LEN    = 64;
    localparam int         ALIGN_PERIOD = 16;
    localparam int         GW           = 2;
    localparam logic [7:0] IDLE_K       = 8'hBC;
    localparam logic [7:0] SOF_K        = 8'hFB;
    localparam logic [7:0] EOF_K        = 8'hFD;
    localparam logic [7:0] FILL_K       = 8'h1C;

    typedef struct packed {
        logic [7:0]         data;
        logic               k;
        logic               link;
        logic [GW-1:0]      gnt;
        logic               busy;
        logic [NUM_REQ-1:0] rdy;
    } exp_t;

    logic                 clk_byte      = 1'b0;
    logic                 rst           = 1'b1;
    logic                 enable        = 1'b0;
    logic                 train_restart = 1'b0;
    logic [NUM_REQ-1:0]   req_valid     = '0;
    logic [NUM_REQ*8-1:0] req_data      = '0;
    logic [NUM_REQ-1:0]   req_last      = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_k;
    logic                 link_up;
    logic [GW-1:0]        grant_id;
    logic                 busy;
`ifdef TX_SCHED_STATS_EN
    logic [15:0]          frame_count;
    logic [15:0]          align_count;
`endif

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [8:0] src_q[NUM_REQ][$];
    bit         mid_pkt[NUM_REQ];

    string      phase;
    int         tr_left;
    bit         m_link;
    int         m_grant;
    bit         m_due;
    int         cyc;
    bit         en_state;

    int         total  = 0;
    int         bad    = 0;
    bit         mon_en = 1'b0;

    tx_link_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .TRAIN_LEN    (TRAIN_LEN),
        .ALIGN_PERIOD (ALIGN_PERIOD),
        .IDLE_K       (IDLE_K),
        .SOF_K        (SOF_K),
        .EOF_K        (EOF_K),
        .FILL_K       (FILL_K)
    ) dut (
        .clk_byte      (clk_byte),
        .rst           (rst),
        .enable        (enable),
        .train_restart (train_restart),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_k          (tx_k),
        .link_up       (link_up),
        .grant_id      (grant_id),
        .busy          (busy)
`ifdef TX_SCHED_STATS_EN
        ,
        .frame_count   (frame_count),
        .align_count   (align_count)
`endif
    );

    always #5 clk_byte = ~clk_byte;

    task automatic cmpVal(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmpVal("tx_data",   32'(tx_data),   32'(e.data));
        cmpVal("tx_k",      32'(tx_k),      32'(e.k));
        cmpVal("link_up",   32'(link_up),   32'(e.link));
        cmpVal("grant_id",  32'(grant_id),  32'(e.gnt));
        cmpVal("busy",      32'(busy),      32'(e.busy));
        cmpVal("req_ready", 32'(req_ready), 32'(e.rdy));
    endtask

    // Reference model: predicts the symbol chosen this cycle and the state seen after the edge.
    task automatic modelStep(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*8-1:0] d,
                             input logic [NUM_REQ-1:0] l, input bit en, input bit rs);
        string      ph_before;
        bit         clear_due;
        bit         found;
        bit         done;
        logic [7:0] sym;
        bit         k;
        int         s;
        logic [8:0] beat;
        exp_t       e;

        ph_before = phase;
        clear_due = (phase == "train") || (phase == "idle") || (phase == "data" && m_due);
        sym = IDLE_K;
        k   = 1'b1;

        if (phase == "train") begin
            tr_left--;
            if (tr_left == 0) begin
                m_link = 1'b1;
                phase  = "idle";
            end
        end else if (phase == "idle") begin
            if (en && (v != '0)) begin
                found = 1'b0;
                for (int j = 1; j <= NUM_REQ; j++) begin
                    s = (m_grant + j) % NUM_REQ;
                    if (!found && v[s]) begin
                        found   = 1'b1;
                        m_grant = s;
                    end
                end
                phase = "sof";
            end
        end else if (phase == "sof") begin
            sym   = SOF_K;
            phase = "data";
        end else if (phase == "data") begin
            if (m_due) begin
                sym = IDLE_K;
            end else if (v[m_grant]) begin
                sym  = d[m_grant*8 +: 8];
                k    = 1'b0;
                beat = src_q[m_grant].pop_front();
                mid_pkt[m_grant] = !beat[8];
                if (l[m_grant]) phase = "eof";
            end else begin
                sym = FILL_K;
            end
        end else if (phase == "eof") begin
            sym   = EOF_K;
            phase = "idle";
        end

        m_due = ((cyc % ALIGN_PERIOD) == ALIGN_PERIOD - 1) || (m_due && !clear_due);

        if (rs) begin
            phase   = "train";
            tr_left = TRAIN_LEN;
            m_link  = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (mid_pkt[i]) begin
                    done = 1'b0;
                    while (!done && src_q[i].size() > 0) begin
                        beat = src_q[i].pop_front();
                        done = beat[8];
                    end
                    mid_pkt[i] = 1'b0;
                end
            end
        end
        cyc++;

        e.data = sym;
        e.k    = k;
        e.link = m_link;
        e.gnt  = GW'(m_grant);
        e.busy = (ph_before == "sof") || (ph_before == "data") || (ph_before == "eof");
        e.rdy  = '0;
        if (phase == "data" && !m_due) e.rdy[m_grant] = 1'b1;
        exp_q.push_back(e);
    endtask

    // Drives one cycle of random traffic, feeds the model, then advances past the next edge.
    task automatic applyStimulus(input int vprob, input int pkt_prob, input bit allow_en_toggle,
                                 input bit allow_restart);
        logic [NUM_REQ-1:0]   v;
        logic [NUM_REQ-1:0]   l;
        logic [NUM_REQ*8-1:0] d;
        bit                   rs;
        int                   len;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() == 0 && $urandom_range(0, 99) < pkt_prob) begin
                len = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 6));
                for (int b = 0; b < len; b++) begin
                    src_q[i].push_back({(b == len - 1), 8'($urandom)});
                end
            end
        end
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0) begin
                d[i*8 +: 8] = src_q[i][0][7:0];
                l[i]        = src_q[i][0][8];
                v[i]        = ($urandom_range(0, 99) < vprob);
            end
        end
        if (allow_en_toggle) begin
            if (en_state && $urandom_range(0, 79) == 0) en_state = 1'b0;
            else if (!en_state && $urandom_range(0, 9) == 0) en_state = 1'b1;
        end
        rs = allow_restart && ($urandom_range(0, 299) == 0);

        req_valid     = v;
        req_data      = d;
        req_last      = l;
        enable        = en_state;
        train_restart = rs;
        modelStep(v, d, l, en_state, rs);
        @(posedge clk_byte);
        #1;
    endtask

    task automatic doReset();
        exp_t e;
        mon_en = 1'b0;
        exp_q.delete();
        rst           = 1'b1;
        req_valid     = '0;
        req_data      = '0;
        req_last      = '0;
        enable        = 1'b0;
        train_restart = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            mid_pkt[i] = 1'b0;
        end
        #1;
        e.data = IDLE_K;
        e.k    = 1'b1;
        e.link = 1'b0;
        e.gnt  = '0;
        e.busy = 1'b0;
        e.rdy  = '0;
        exp_q.push_back(e);
        mon_en = 1'b1;
        @(negedge clk_byte);
        #1;
        @(posedge clk_byte);
        #1;
        rst      = 1'b0;
        phase    = "train";
        tr_left  = TRAIN_LEN;
        m_link   = 1'b0;
        m_grant  = 0;
        m_due    = 1'b0;
        cyc      = 0;
        en_state = 1'b1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_byte) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL scoreboard_empty at t=%0t: got no entry expected one", $time);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput(mon_e);
            end
        end
    end

    initial begin
        $display("[TB] start");
        doReset();
        repeat (80)   applyStimulus(0, 0, 1'b0, 1'b0);
        repeat (3000) applyStimulus(85, 20, 1'b1, 1'b1);
        doReset();
        repeat (1500) applyStimulus(60, 30, 1'b1, 1'b1);
        @(negedge clk_byte);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
